// File: rtl/cmp_pkg.sv
// Shared constants for the comparator-sharing arbiter: branch funct3 codes,
// comparator result bit positions, response source ids and buffer states.
package cmp_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Bit positions inside the 3-bit comparator result {EQ, SL, UL}
    localparam int CMP_EQ = 2;
    localparam int CMP_SL = 1;
    localparam int CMP_UL = 0;

    localparam logic SRC_BR = 1'b0;
    localparam logic SRC_SL = 1'b1;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

    // Branch decode, returns {illegal, result}. 010/011 are not branches.
    function automatic logic [1:0] br_decode(input logic [2:0] funct3, input logic [2:0] cmp);
        case (funct3)
            F3_BEQ:  br_decode = {1'b0,  cmp[CMP_EQ]};
            F3_BNE:  br_decode = {1'b0, ~cmp[CMP_EQ]};
            F3_BLT:  br_decode = {1'b0,  cmp[CMP_SL]};
            F3_BGE:  br_decode = {1'b0, ~cmp[CMP_SL]};
            F3_BLTU: br_decode = {1'b0,  cmp[CMP_UL]};
            F3_BGEU: br_decode = {1'b0, ~cmp[CMP_UL]};
            default: br_decode = 2'b10;
        endcase
    endfunction

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Request (BR, SL) and response handshake bundle of the comparator arbiter.
// slave = arbiter side, master = issue/writeback side.
interface cmp_share_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             br_valid;
    logic             br_ready;
    logic [31:0]      br_a;
    logic [31:0]      br_b;
    logic [2:0]       br_funct3;
    logic [TAG_W-1:0] br_tag;

    logic             sl_valid;
    logic             sl_ready;
    logic [31:0]      sl_a;
    logic [31:0]      sl_b;
    logic             sl_unsigned;
    logic [TAG_W-1:0] sl_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_src;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_result;
    logic             rsp_illegal;

    modport slave (
        input  br_valid, br_a, br_b, br_funct3, br_tag,
        output br_ready,
        input  sl_valid, sl_a, sl_b, sl_unsigned, sl_tag,
        output sl_ready,
        output rsp_valid, rsp_src, rsp_tag, rsp_result, rsp_illegal,
        input  rsp_ready
    );

    modport master (
        output br_valid, br_a, br_b, br_funct3, br_tag,
        input  br_ready,
        output sl_valid, sl_a, sl_b, sl_unsigned, sl_tag,
        input  sl_ready,
        input  rsp_valid, rsp_src, rsp_tag, rsp_result, rsp_illegal,
        output rsp_ready
    );
endinterface

// File: rtl/cmp_rsp_fifo2.sv
// Two-entry response buffer. The head register drives the response outputs
// directly, so they are registered and hold while the consumer stalls.
//
//  state      | meaning
//  FIFO_EMPTY | nothing buffered, rsp_valid low
//  FIFO_ONE   | head valid, tail free; push and pop may happen together
//  FIFO_FULL  | head and tail valid, no push accepted
module cmp_rsp_fifo2
    import cmp_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_ready_i,
    output logic         valid_o,
    output logic [W-1:0] dout_o,
    output logic         accept_ok_o
);

    fifo_state_e  state_q;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         pop;

    assign pop         = (state_q != FIFO_EMPTY) && pop_ready_i;
    assign valid_o     = (state_q != FIFO_EMPTY);
    assign accept_ok_o = (state_q != FIFO_FULL);
    assign dout_o      = head_q;

    // Occupancy FSM plus head/tail storage; head always holds the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FIFO_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                FIFO_EMPTY: begin
                    if (push_i) begin
                        head_q  <= din_i;
                        state_q <= FIFO_ONE;
                    end
                end
                FIFO_ONE: begin
                    if (push_i && pop) begin
                        head_q <= din_i;
                    end else if (push_i) begin
                        tail_q  <= din_i;
                        state_q <= FIFO_FULL;
                    end else if (pop) begin
                        state_q <= FIFO_EMPTY;
                    end
                end
                FIFO_FULL: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= FIFO_ONE;
                    end
                end
                default: state_q <= FIFO_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// One 32-bit comparator shared between the branch unit and the SLT/SLTU path.
// Round-robin grant, same-cycle compare/decode, result pushed into a 2-entry
// response buffer (1-cycle latency). Requester readiness depends only on
// buffer occupancy, never on rsp_ready.
module cmp_share_arbiter
    import cmp_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cmp_share_arbiter_if.slave    bus
);

    // Entry layout: {src, illegal, result, tag}
    localparam int ENT_W = 3 + TAG_W;

    logic             last_grant_q;
    logic             grant_br;
    logic             grant_sl;
    logic             accept_ok;
    logic             push;
    logic [31:0]      cmp_a;
    logic [31:0]      cmp_b;
    logic [2:0]       cmp_res;
    logic             res_bit;
    logic             ill_bit;
    logic [TAG_W-1:0] tag_sel;
    logic [ENT_W-1:0] push_data;
    logic [ENT_W-1:0] head;
    logic             rsp_vld;

    // Round-robin grant: on contention the port that did not win last goes.
    always_comb begin
        grant_sl = bus.sl_valid && (!bus.br_valid || (last_grant_q == SRC_BR));
        grant_br = bus.br_valid && !grant_sl;
    end

    assign bus.br_ready = grant_br && accept_ok;
    assign bus.sl_ready = grant_sl && accept_ok;
    assign push         = (bus.br_valid && bus.br_ready) || (bus.sl_valid && bus.sl_ready);

    // Operand mux, the single shared comparator and result decode.
    always_comb begin
        cmp_a   = grant_sl ? bus.sl_a : bus.br_a;
        cmp_b   = grant_sl ? bus.sl_b : bus.br_b;
        cmp_res = '0;
        cmp_res[CMP_EQ] = (cmp_a == cmp_b);
        cmp_res[CMP_SL] = ($signed(cmp_a) < $signed(cmp_b));
        cmp_res[CMP_UL] = (cmp_a < cmp_b);
        if (grant_sl) begin
            res_bit = bus.sl_unsigned ? cmp_res[CMP_UL] : cmp_res[CMP_SL];
            ill_bit = 1'b0;
            tag_sel = bus.sl_tag;
        end else begin
            {ill_bit, res_bit} = br_decode(bus.br_funct3, cmp_res);
            tag_sel = bus.br_tag;
        end
        push_data = {grant_sl ? SRC_SL : SRC_BR, ill_bit, res_bit, tag_sel};
    end

    // Round-robin history only moves on a real transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= SRC_SL;
        end else if (push) begin
            last_grant_q <= grant_sl ? SRC_SL : SRC_BR;
        end
    end

    cmp_rsp_fifo2 #(
        .W (ENT_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .din_i       (push_data),
        .pop_ready_i (bus.rsp_ready),
        .valid_o     (rsp_vld),
        .dout_o      (head),
        .accept_ok_o (accept_ok)
    );

    assign bus.rsp_valid   = rsp_vld;
    assign bus.rsp_src     = head[ENT_W-1];
    assign bus.rsp_illegal = head[ENT_W-2];
    assign bus.rsp_result  = head[ENT_W-3];
    assign bus.rsp_tag     = head[TAG_W-1:0];

endmodule
